// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the generic pipeline stage register: per-stage default widths,
// control-bit field positions and the main-register source select.
package pipe_stage_reg_pkg;

    localparam int PIPE_IFID_DATA_W  = 64;
    localparam int PIPE_IFID_CTRL_W  = 8;
    localparam int PIPE_IDEX_DATA_W  = 128;
    localparam int PIPE_IDEX_CTRL_W  = 24;
    localparam int PIPE_EXMEM_DATA_W = 96;
    localparam int PIPE_EXMEM_CTRL_W = 16;
    localparam int PIPE_MEMWB_DATA_W = 64;
    localparam int PIPE_MEMWB_CTRL_W = 8;

    // Control-bit positions used when packing the ctrl bus of a stage
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MFHI     = 3;
    localparam int CTRL_MFLO     = 4;
    localparam int CTRL_EXC_OVF  = 5;
    localparam int CTRL_EXC_SYS  = 6;
    localparam int CTRL_EXC_BRK  = 7;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_INPUT = 2'd1,
        SRC_SKID  = 2'd2
    } main_src_e;

    // The main register may take a new value when it is empty or being drained
    function automatic logic main_can_load(input logic vld, input logic out_rdy);
        return ~vld | out_rdy;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One storage slot (valid + payload + control) with clear and load; ctrl is zeroed
// whenever the slot is loaded empty so a bubble never carries live control bits.
module pipe_stage_reg_slot #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 24
) (
    input  logic              i_clock,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_vld;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(negedge i_clock) begin
        if (i_clear) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_ctrl <= '0;
        end else if (i_load) begin
            r_vld  <= i_vld;
            r_ctrl <= i_vld ? i_ctrl : '0;
            if (i_vld)
                r_data <= i_data;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with flush and bubble-safe control bits.
// Define PIPE_REG_SKID_EN for a second (skid) entry and a registered o_in_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 24
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic [CTRL_W-1:0] o_out_ctrl
);

    logic              w_clear;
    logic              w_accept;
    logic              w_main_load;
    main_src_e         w_main_src;
    logic              w_main_vld;
    logic [DATA_W-1:0] w_main_data;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic              w_main_d_vld;
    logic [DATA_W-1:0] w_main_d_data;
    logic [CTRL_W-1:0] w_main_d_ctrl;

    assign w_clear     = i_reset | i_flush;
    assign w_accept    = i_in_valid & o_in_ready;
    assign w_main_load = main_can_load(w_main_vld, i_out_ready);

`ifdef PIPE_REG_SKID_EN
    logic              w_skid_vld;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic              w_skid_load;

    // in_ready depends only on skid state, so out_ready never reaches it combinationally
    assign o_in_ready  = ~w_skid_vld;
    // Full skid empties into main when main loads; empty skid catches an entry main cannot take
    assign w_skid_load = w_skid_vld ? w_main_load : (w_accept & ~w_main_load);

    always_comb begin
        w_main_src = SRC_NONE;
        if (w_skid_vld)
            w_main_src = SRC_SKID;
        else if (w_accept)
            w_main_src = SRC_INPUT;
    end

    pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .i_clock (i_clock),
        .i_clear (w_clear),
        .i_load  (w_skid_load),
        .i_vld   (~w_skid_vld),
        .i_data  (i_in_data),
        .i_ctrl  (i_in_ctrl),
        .o_vld   (w_skid_vld),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );
`else
    assign o_in_ready = i_out_ready | ~w_main_vld;

    always_comb begin
        w_main_src = SRC_NONE;
        if (w_accept)
            w_main_src = SRC_INPUT;
    end
`endif

    always_comb begin
        w_main_d_vld  = 1'b0;
        w_main_d_data = i_in_data;
        w_main_d_ctrl = '0;
        case (w_main_src)
            SRC_INPUT: begin
                w_main_d_vld  = 1'b1;
                w_main_d_data = i_in_data;
                w_main_d_ctrl = i_in_ctrl;
            end
`ifdef PIPE_REG_SKID_EN
            SRC_SKID: begin
                w_main_d_vld  = 1'b1;
                w_main_d_data = w_skid_data;
                w_main_d_ctrl = w_skid_ctrl;
            end
`endif
            default: ;
        endcase
    end

    pipe_stage_reg_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .i_clock (i_clock),
        .i_clear (w_clear),
        .i_load  (w_main_load),
        .i_vld   (w_main_d_vld),
        .i_data  (w_main_d_data),
        .i_ctrl  (w_main_d_ctrl),
        .o_vld   (w_main_vld),
        .o_data  (w_main_data),
        .o_ctrl  (w_main_ctrl)
    );

    assign o_out_valid = w_main_vld;
    assign o_out_data  = w_main_data;
    assign o_out_ctrl  = w_main_ctrl;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table, corner sequences and random traffic against a
// queue model of the stage. Works with or without PIPE_REG_SKID_EN defined.
module tb_pipe_stage_reg;

    localparam int DW = 64;
    localparam int CW = 24;
`ifdef PIPE_REG_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam logic [CW-1:0] ONES = {CW{1'b1}};

    logic          clk = 1'b0;
    logic          rst, fl, iv, ordy;
    logic [DW-1:0] idata;
    logic [CW-1:0] ictrl;
    logic          irdy, ovld;
    logic [DW-1:0] odata;
    logic [CW-1:0] octrl;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_flush     (fl),
        .i_in_valid  (iv),
        .o_in_ready  (irdy),
        .i_in_data   (idata),
        .i_in_ctrl   (ictrl),
        .o_out_valid (ovld),
        .i_out_ready (ordy),
        .o_out_data  (odata),
        .o_out_ctrl  (octrl)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } ent_t;

    typedef struct {
        logic          rs, fl, iv;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ordy;
        logic          ev;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        logic          chk_d, chk_r;
    } vec_t;

    ent_t          q[$];
    logic [DW-1:0] hold;
    int            n_checks = 0;
    int            n_pass   = 0;
    logic          last_acc;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        else
            n_pass++;
    endtask

    function automatic logic model_ready(input logic out_rdy);
`ifdef PIPE_REG_SKID_EN
        return q.size() < 2;
`else
        return (q.size() == 0) || out_rdy;
`endif
    endfunction

    // One clock: drive, check in_ready, take the edge, advance the model, check outputs
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic r, input logic f, input logic rs);
        logic mrdy;
        ent_t e;
        rst = rs; fl = f; iv = v; idata = d; ictrl = c; ordy = r;
        #1;
        mrdy = model_ready(r);
        if (!rs) chk("in_ready", {63'd0, irdy}, {63'd0, mrdy});
        last_acc = v & mrdy;
        @(negedge clk); #1;
        if (rs || f) begin
            q.delete();
            hold = '0;
        end else begin
            if (q.size() > 0 && r) void'(q.pop_front());
            if (v && mrdy) begin
                e.d = d; e.c = c;
                q.push_back(e);
            end
            if (q.size() > 0) hold = q[0].d;
        end
        chk("out_valid", {63'd0, ovld}, {63'd0, q.size() > 0});
        chk("out_ctrl", {40'd0, octrl}, (q.size() > 0) ? {40'd0, q[0].c} : 64'd0);
        chk("out_data", odata, (q.size() > 0) ? q[0].d : hold);
    endtask

    vec_t tbl[15];

    initial begin
        int held, cnt;
        rst = 1'b1; fl = 1'b0; iv = 1'b0; ordy = 1'b1; idata = '0; ictrl = '0;
        hold = '0;

        for (int i = 0; i < 3; i++)
            tbl[i] = '{1, 0, 1, 64'hDEAD, ONES, 1, 0, 64'd0, '0, 1, 1};
        for (int i = 0; i < 8; i++)
            tbl[3+i] = '{0, 0, 1, 64'(i+1), ONES, 1, 1, 64'(i+1), ONES, 1, 1};
        tbl[11] = '{0, 0, 0, 64'd0, '0, 1, 0, 64'd0, '0, 0, 1};
        tbl[12] = '{0, 0, 1, 64'h55, 24'h123456, 0, 1, 64'h55, 24'h123456, 1, 0};
        tbl[13] = '{0, 0, 0, 64'd0, '0, 1, 0, 64'd0, '0, 0, 1};
        tbl[14] = '{0, 1, 1, 64'd9, ONES, 1, 0, 64'd0, '0, 1, 1};

        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].ordy, tbl[i].fl, tbl[i].rs);
            chk($sformatf("tbl%0d_valid", i), {63'd0, ovld}, {63'd0, tbl[i].ev});
            chk($sformatf("tbl%0d_ctrl", i), {40'd0, octrl}, {40'd0, tbl[i].ec});
            if (tbl[i].chk_d) chk($sformatf("tbl%0d_data", i), odata, tbl[i].ed);
            if (tbl[i].chk_r) chk($sformatf("tbl%0d_ready", i), {63'd0, irdy}, 64'd1);
        end

        // Stall with stream active: stage fills to its capacity, nothing lost on release
        cycle(1, 64'd100, 24'h1, 1, 0, 0);
        held = 1;
        for (int i = 0; i < 4; i++) begin
            cycle(1, 64'(101 + i), 24'h2, 0, 0, 0);
            if (last_acc) held++;
        end
        chk("stall_held", 64'(held), 64'(CAP));
        chk("stall_in_ready", {63'd0, irdy}, 64'd0);
        chk("stall_head", odata, 64'd100);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 64'd0, 24'h0, 1, 0, 0);
            if (ovld) begin
                cnt++;
                chk("drain_data", odata, 64'd101);
            end
        end
        chk("drain_count", 64'(cnt), 64'(CAP - 1));

        // Flush with the stage full and a new entry offered
        cycle(1, 64'd200, 24'hA, 0, 0, 0);
        cycle(1, 64'd201, 24'hB, 0, 0, 0);
        cycle(1, 64'd9, ONES, 0, 1, 0);
        chk("flush_valid", {63'd0, ovld}, 64'd0);
        chk("flush_ctrl", {40'd0, octrl}, 64'd0);
        chk("flush_ready", {63'd0, irdy}, 64'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 64'd0, 24'h0, 1, 0, 0);
            chk("flush_no9", {63'd0, ovld}, 64'd0);
        end

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom % 4) != 0, {$urandom, $urandom}, 24'($urandom),
                  ($urandom % 3) != 0, ($urandom % 32) == 0, ($urandom % 200) == 0);
        end
        for (int i = 0; i < 3; i++) cycle(0, 64'd0, 24'h0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
